// File: rtl/hcsr04_avalon_responder.sv
// Avalon-MM responder for an HC-SR04 ultrasonic ranger: trigger generation,
// echo timing in microsecond ticks, cm/us results, sticky flags and irq.
module hcsr04_avalon_responder #(
    parameter int CLK_FREQ_HZ = 50000000,
    parameter int TRIG_US     = 10,
    parameter int TIMEOUT_US  = 30000,
    parameter int PERIOD_US   = 60000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  avs_address,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic [31:0] avs_readdata,
    output logic        irq,
    output logic        trig,
    input  logic        echo
);
    localparam int DIV    = CLK_FREQ_HZ / 1000000;
    localparam int PW     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CM_DIV = 58;

    typedef enum logic [2:0] {S_IDLE, S_TRIG, S_WAIT, S_MEAS, S_HOLD} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [31:0]   cnt_q, cnt_d;
    logic [31:0]   per_q, per_d;
    logic [5:0]    sub_q, sub_d;
    logic [9:0]    cm_q, cm_d;
    logic [2:0]    echo_sync_q;
    logic          start_q, cont_q, irq_en_q, done_q, tmo_q, trig_q;
    logic [9:0]    dist_q;
    logic [15:0]   echo_us_q;
    logic [31:0]   rdata_q, rd_mux;
    logic          tick, echo_rise, echo_fall, set_done, set_tmo, enter_trig;
    logic          wr_ctrl, wr_status;
    logic          unused_wdata;

    assign unused_wdata = ^avs_writedata[31:3];

    assign wr_ctrl   = avs_write && (avs_address == 2'd0);
    assign wr_status = avs_write && (avs_address == 2'd1);
    assign tick      = (state_q != S_IDLE) && (pre_q == PW'(DIV - 1));
    // [0],[1] synchronize; [2] is the previous synchronized value for edges
    assign echo_rise = echo_sync_q[1] & ~echo_sync_q[2];
    assign echo_fall = ~echo_sync_q[1] & echo_sync_q[2];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sub_d    = sub_q;
        cm_d     = cm_q;
        set_done = 1'b0;
        set_tmo  = 1'b0;
        per_d    = (tick && per_q != 32'(PERIOD_US)) ? per_q + 32'd1 : per_q;
        case (state_q)
            S_IDLE: begin
                if (start_q || cont_q) state_d = S_TRIG;
            end
            S_TRIG: begin
                if (tick) begin
                    if (cnt_q == 32'(TRIG_US - 1)) begin
                        state_d = S_WAIT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end
            end
            S_WAIT: begin
                // a tick coincident with the rise is counted so the measured
                // window equals the echo width in cycles
                if (echo_rise) begin
                    state_d = S_MEAS;
                    cnt_d   = {31'd0, tick};
                    sub_d   = {5'd0, tick};
                    cm_d    = '0;
                end else if (tick) begin
                    if (cnt_q == 32'(TIMEOUT_US - 1)) begin
                        state_d = S_HOLD;
                        set_tmo = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end
            end
            S_MEAS: begin
                if (echo_fall) begin
                    state_d  = S_HOLD;
                    set_done = 1'b1;
                end else if (tick) begin
                    if (cnt_q == 32'(TIMEOUT_US - 1)) begin
                        state_d = S_HOLD;
                        set_tmo = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                        if (sub_q == 6'(CM_DIV - 1)) begin
                            sub_d = '0;
                            if (cm_q != 10'h3FF) cm_d = cm_q + 10'd1;
                        end else begin
                            sub_d = sub_q + 6'd1;
                        end
                    end
                end
            end
            S_HOLD: begin
                // going straight back to TRIG keeps continuous-mode spacing exact
                if (per_q == 32'(PERIOD_US) || (tick && per_q == 32'(PERIOD_US - 1)))
                    state_d = cont_q ? S_TRIG : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        enter_trig = (state_d == S_TRIG) && (state_q != S_TRIG);
        if (enter_trig) begin
            cnt_d = '0;
            per_d = '0;
        end
        if (state_q == S_IDLE || enter_trig || pre_q == PW'(DIV - 1))
            pre_d = '0;
        else
            pre_d = pre_q + PW'(1);
    end

    always_comb begin
        rd_mux = '0;
        case (avs_address)
            2'd0:    rd_mux = {29'd0, irq_en_q, cont_q, 1'b0};
            2'd1:    rd_mux = {29'd0, tmo_q, done_q, state_q != S_IDLE};
            2'd2:    rd_mux = {22'd0, dist_q};
            default: rd_mux = {16'd0, echo_us_q};
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            pre_q       <= '0;
            cnt_q       <= '0;
            per_q       <= '0;
            sub_q       <= '0;
            cm_q        <= '0;
            echo_sync_q <= '0;
            start_q     <= 1'b0;
            cont_q      <= 1'b0;
            irq_en_q    <= 1'b0;
            done_q      <= 1'b0;
            tmo_q       <= 1'b0;
            trig_q      <= 1'b0;
            dist_q      <= '0;
            echo_us_q   <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            pre_q       <= pre_d;
            cnt_q       <= cnt_d;
            per_q       <= per_d;
            sub_q       <= sub_d;
            cm_q        <= cm_d;
            echo_sync_q <= {echo_sync_q[1:0], echo};
            trig_q      <= (state_d == S_TRIG);
            start_q     <= wr_ctrl & avs_writedata[0];
            if (wr_ctrl) begin
                cont_q   <= avs_writedata[1];
                irq_en_q <= avs_writedata[2];
            end
            done_q <= set_done | (done_q & ~(wr_status & avs_writedata[1]));
            tmo_q  <= set_tmo  | (tmo_q  & ~(wr_status & avs_writedata[2]));
            if (set_done) begin
                dist_q    <= cm_q;
                echo_us_q <= (cnt_q > 32'h0000_FFFF) ? 16'hFFFF : cnt_q[15:0];
            end
            if (avs_read) rdata_q <= rd_mux;
        end
    end

    assign avs_readdata = rdata_q;
    assign trig         = trig_q;
    assign irq          = irq_en_q & (done_q | tmo_q);

endmodule

// File: tb/tb_hcsr04_avalon_responder.sv
// Bench for hcsr04_avalon_responder: register vectors, directed timing corners
// and randomized measurements checked against an outcome model.
module tb_hcsr04_avalon_responder;
    localparam int CLK_HZ = 2000000;
    localparam int DIV    = CLK_HZ / 1000000;
    localparam int TRIG   = 10;
    localparam int TO     = 700;
    localparam int PER    = 1500;
    localparam int TD     = TRIG * DIV;
    localparam int PD     = PER * DIV;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  avs_address = '0;
    logic        avs_read = 1'b0;
    logic        avs_write = 1'b0;
    logic [31:0] avs_writedata = '0;
    logic [31:0] avs_readdata;
    logic        irq, trig;
    logic        echo = 1'b0;

    hcsr04_avalon_responder #(
        .CLK_FREQ_HZ(CLK_HZ), .TRIG_US(TRIG), .TIMEOUT_US(TO), .PERIOD_US(PER)
    ) dut (
        .clk(clk), .reset(reset), .avs_address(avs_address), .avs_read(avs_read),
        .avs_write(avs_write), .avs_writedata(avs_writedata),
        .avs_readdata(avs_readdata), .irq(irq), .trig(trig), .echo(echo)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   trig_rises = 0;
    logic trig_prev = 1'b0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        trig_prev <= trig;
        if (trig && !trig_prev) trig_rises <= trig_rises + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1);
    end

    int checks = 0;
    int failures = 0;
    // outcome model: last successful echo width in us, if any
    bit m_have = 1'b0;
    int m_w = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
        end
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        avs_address = a; avs_writedata = d; avs_write = 1'b1;
        @(negedge clk);
        avs_write = 1'b0; avs_writedata = '0;
    endtask

    task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
        avs_address = a; avs_read = 1'b1;
        @(negedge clk);
        avs_read = 1'b0;
        d = avs_readdata;
    endtask

    task automatic rd_chk(input string nm, input logic [1:0] a, input int exp);
        logic [31:0] d;
        bus_rd(a, d);
        chk(nm, int'(d), exp);
    endtask

    task automatic chk_results(input string nm);
        logic [31:0] d, e;
        bus_rd(2'd2, d);
        bus_rd(2'd3, e);
        if (m_have) begin
            chk_rng({nm, "_echo_us"}, int'(e), m_w - 1, m_w + 1);
            chk_rng({nm, "_dist_cm"}, int'(d), (m_w - 1) / 58, (m_w + 1) / 58);
        end else begin
            chk({nm, "_echo_us"}, int'(e), 0);
            chk({nm, "_dist_cm"}, int'(d), 0);
        end
    endtask

    // write CTRL, check 2-cycle trigger latency and exact pulse width;
    // returns at the first cycle after trig falls
    task automatic launch(input logic [31:0] ctrl, output int t0);
        int n;
        bus_wr(2'd0, ctrl);
        chk("trig_latency_early", int'(trig), 0);
        @(negedge clk);
        chk("trig_latency", int'(trig), 1);
        t0 = cyc;
        n = 0;
        while (trig && n < 10000) begin
            @(negedge clk);
            n++;
        end
        chk("trig_width", n, TD);
    endtask

    typedef struct {
        logic        wr;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[10];

    int t0, t1, rb, fb, tt, r0, n, kind, dly, wid, exp_st;
    logic [31:0] d;

    initial begin
        vecs[0] = '{1'b0, 2'd0, 32'h0, 32'h0};
        vecs[1] = '{1'b0, 2'd1, 32'h0, 32'h0};
        vecs[2] = '{1'b0, 2'd2, 32'h0, 32'h0};
        vecs[3] = '{1'b0, 2'd3, 32'h0, 32'h0};
        vecs[4] = '{1'b1, 2'd0, 32'h4, 32'h4};
        vecs[5] = '{1'b1, 2'd1, 32'h6, 32'h0};
        vecs[6] = '{1'b1, 2'd2, 32'h3FF, 32'h0};
        vecs[7] = '{1'b1, 2'd3, 32'hFFFF, 32'h0};
        vecs[8] = '{1'b1, 2'd0, 32'hFFFF_FFF8, 32'h0};
        vecs[9] = '{1'b1, 2'd0, 32'h2_0004, 32'h4};

        repeat (3) @(negedge clk);
        chk("reset_trig", int'(trig), 0);
        chk("reset_irq", int'(irq), 0);
        chk("reset_rdata", int'(avs_readdata), 0);
        reset = 1'b0;
        @(negedge clk);

        // register access vectors
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].wr) bus_wr(vecs[i].addr, vecs[i].wdata);
            bus_rd(vecs[i].addr, d);
            chk($sformatf("vec%0d_rd", i), int'(d), int'(vecs[i].exp));
            chk($sformatf("vec%0d_irq", i), int'(irq), 0);
            chk($sformatf("vec%0d_trig", i), int'(trig), 0);
        end

        // 580 us echo, plus a START while busy
        launch(32'h5, t0);
        rd_chk("busy_in_wait", 2'd1, 1);
        r0 = trig_rises;
        wait_cyc(t0 + TD + 10);
        bus_wr(2'd0, 32'h5);
        rb = t0 + TD + 100 * DIV;
        wait_cyc(rb); echo = 1'b1;
        fb = rb + 580 * DIV;
        wait_cyc(fb); echo = 1'b0;
        wait_cyc(fb + 10);
        rd_chk("done_in_holdoff", 2'd1, 3);
        m_have = 1'b1; m_w = 580;
        chk_results("meas580");
        chk("irq_on_done", int'(irq), 1);
        wait_cyc(t0 + PD - 1);
        rd_chk("holdoff_last_cycle", 2'd1, 3);
        rd_chk("idle_after_holdoff", 2'd1, 2);
        wait_cyc(t0 + PD + 20);
        chk("start_while_busy_ignored", trig_rises - r0, 0);
        bus_wr(2'd1, 32'h2);
        chk("irq_after_w1c", int'(irq), 0);
        rd_chk("status_after_w1c", 2'd1, 0);

        // no echo: wait timeout, with W1C landing on the setting cycle
        launch(32'h5, t0);
        tt = t0 + TD + TO * DIV;
        wait_cyc(tt - 2);
        rd_chk("wait_before_timeout", 2'd1, 1);
        bus_wr(2'd1, 32'h4);
        rd_chk("timeout_set_wins", 2'd1, 5);
        chk("irq_on_timeout", int'(irq), 1);
        chk_results("after_wait_timeout");
        wait_cyc(t0 + PD);
        rd_chk("idle_after_timeout", 2'd1, 4);
        bus_wr(2'd1, 32'h4);

        // echo held high longer than the timeout
        launch(32'h5, t0);
        rb = t0 + TD + 50 * DIV;
        wait_cyc(rb); echo = 1'b1;
        wait_cyc(rb + (TO - 1) * DIV + 1);
        rd_chk("meas_before_timeout", 2'd1, 1);
        wait_cyc(rb + TO * DIV + 4);
        rd_chk("width_timeout", 2'd1, 5);
        wait_cyc(rb + (TO + 50) * DIV); echo = 1'b0;
        chk_results("after_width_timeout");
        wait_cyc(t0 + PD);
        rd_chk("idle_after_width_timeout", 2'd1, 4);
        bus_wr(2'd1, 32'h6);

        // continuous mode, then clear CONT mid-measurement
        launch(32'h6, t0);
        rb = t0 + TD + 50 * DIV;
        wait_cyc(rb); echo = 1'b1;
        wait_cyc(rb + 200 * DIV); echo = 1'b0;
        wait_cyc(rb + 200 * DIV + 10);
        m_w = 200;
        chk_results("cont1");
        n = 0;
        while (!trig && n < PD + 100) begin
            @(negedge clk);
            n++;
        end
        t1 = cyc;
        chk("cont_trig_spacing", t1 - t0, PD);
        rb = t1 + TD + 50 * DIV;
        wait_cyc(rb); echo = 1'b1;
        wait_cyc(rb + 50);
        bus_wr(2'd0, 32'h4);
        wait_cyc(rb + 300 * DIV); echo = 1'b0;
        wait_cyc(rb + 300 * DIV + 10);
        m_w = 300;
        chk_results("cont2");
        r0 = trig_rises;
        wait_cyc(t1 + PD + 400);
        chk("cont_stopped", trig_rises - r0, 0);
        rd_chk("cont_final_status", 2'd1, 2);
        rd_chk("cont_final_ctrl", 2'd0, 4);

        // randomized measurements against the outcome model
        for (int it = 0; it < 6; it++) begin
            bus_wr(2'd1, 32'h6);
            kind = int'($urandom_range(0, 3));
            dly  = int'($urandom_range(5, 300));
            wid  = int'($urandom_range(60, TO - 10));
            launch(32'h5, t0);
            if (kind != 0) begin
                rb = t0 + TD + dly * DIV;
                wait_cyc(rb); echo = 1'b1;
                if (kind == 1) wait_cyc(rb + (TO + 50) * DIV);
                else           wait_cyc(rb + wid * DIV);
                echo = 1'b0;
            end
            if (kind >= 2) begin
                m_have = 1'b1; m_w = wid; exp_st = 2;
            end else begin
                exp_st = 4;
            end
            wait_cyc(t0 + PD);
            rd_chk($sformatf("rand%0d_status", it), 2'd1, exp_st);
            chk($sformatf("rand%0d_irq", it), int'(irq), 1);
            chk_results($sformatf("rand%0d", it));
        end

        // reset while the trigger is high
        bus_wr(2'd0, 32'h5);
        @(negedge clk);
        chk("trig_before_reset", int'(trig), 1);
        reset = 1'b1;
        @(negedge clk);
        chk("trig_dropped_by_reset", int'(trig), 0);
        reset = 1'b0;
        m_have = 1'b0; m_w = 0;
        rd_chk("status_after_reset", 2'd1, 0);
        rd_chk("ctrl_after_reset", 2'd0, 0);
        chk_results("after_reset");
        chk("irq_after_reset", int'(irq), 0);
        repeat (50) @(negedge clk);
        chk("no_trig_after_reset", int'(trig), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
